// File: rtl/pin_probe_pkg.sv
// Shared types for pin_probe: blink FSM states, pin-vector classes, index width helper.
package pin_probe_pkg;

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} class_t;

    // clog2 with a floor of 1 so a single-pin build still has an index bit
    function automatic int idx_w(input int w);
        int r;
        r = 1;
        while (((1 << r) < w) && (r < 31)) r++;
        return r;
    endfunction

endpackage

// File: rtl/pin_probe_if.sv
// Pin/result bundle between the probed header and the pin_probe core.
interface pin_probe_if
    import pin_probe_pkg::*;
#(
    parameter int WIDTH = 48
);
    localparam int IW = idx_w(WIDTH);

    logic [WIDTH-1:0] PMOD;
    logic [IW-1:0]    pin_index;
    logic             pin_valid;
    logic             pin_multi;
    logic             led;

    modport master (output PMOD, input pin_index, pin_valid, pin_multi, led);
    modport slave  (input PMOD, output pin_index, pin_valid, pin_multi, led);
endinterface

// File: rtl/pin_probe_classify.sv
// Combinational classifier: none / single / multi high pins, plus lowest set index.
module pin_probe_classify
    import pin_probe_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int IW    = idx_w(WIDTH)
)(
    input  logic [WIDTH-1:0] i_vec,
    output class_t           o_class,
    output logic [IW-1:0]    o_cand
);
    logic w_multi;

    // clearing the lowest set bit leaves something only if two or more were set
    assign w_multi = |(i_vec & (i_vec - WIDTH'(1)));

    always_comb begin
        o_cand = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (i_vec[i]) o_cand = IW'(i);
        if (i_vec == '0)
            o_class = NONE;
        else if (w_multi)
            o_class = MULTI;
        else
            o_class = SINGLE;
    end
endmodule

// File: rtl/pin_probe.sv
// Finds which PMOD pin is driven high, qualifies it, and blinks its index+1 on the LED.
module pin_probe
    import pin_probe_pkg::*;
#(
    parameter int WIDTH         = 48,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES  = 6_000_000,
    parameter int GAP_CYCLES    = 25_000_000
)(
    input  logic       clk,
    input  logic       resetn,
    pin_probe_if.slave bus
);
    localparam int IW   = idx_w(WIDTH);
    localparam int BW   = IW + 1;
    localparam int TMAX = (BLINK_CYCLES > GAP_CYCLES)
                        ? ((BLINK_CYCLES > STABLE_CYCLES) ? BLINK_CYCLES : STABLE_CYCLES)
                        : ((GAP_CYCLES > STABLE_CYCLES) ? GAP_CYCLES : STABLE_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] STAB_SAT   = TW'(STABLE_CYCLES);
    localparam logic [TW-1:0] STAB_ACC   = TW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
    localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1, r_sync2;
    class_t           w_class, r_class;
    logic [IW-1:0]    w_cand, r_cand;
    logic [TW-1:0]    r_stab;
    logic             w_same, w_accept;
    logic [IW-1:0]    r_index;
    logic             r_valid, r_multi;

    state_t           r_state, w_state;
    logic [TW-1:0]    r_tmr, w_tmr;
    logic [BW-1:0]    r_blinks, w_blinks;
    logic             w_led;

    pin_probe_classify #(.WIDTH(WIDTH), .IW(IW)) u_classify (
        .i_vec   (r_sync2),
        .o_class (w_class),
        .o_cand  (w_cand)
    );

    // accept fires exactly once, on the step that brings the run length to STABLE_CYCLES-1
    assign w_same   = (w_class == r_class) && (w_cand == r_cand);
    assign w_accept = w_same && (r_stab == STAB_ACC);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_class <= NONE;
            r_cand  <= '0;
            r_stab  <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_sync1 <= bus.PMOD;
            r_sync2 <= r_sync1;
            r_class <= w_class;
            r_cand  <= w_cand;
            if (!w_same)
                r_stab <= '0;
            else if (r_stab != STAB_SAT)
                r_stab <= r_stab + TW'(1);
            if (w_accept) begin
                case (w_class)
                    SINGLE: begin
                        r_index <= w_cand;
                        r_valid <= 1'b1;
                        r_multi <= 1'b0;
                    end
                    MULTI: begin
                        r_valid <= 1'b0;
                        r_multi <= 1'b1;
                    end
                    default: begin
                        r_valid <= 1'b0;
                        r_multi <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_tmr    <= '0;
            r_blinks <= '0;
        end else begin
            r_state  <= w_state;
            r_tmr    <= w_tmr;
            r_blinks <= w_blinks;
        end
    end

    // blink count is latched at sequence start so index changes never disturb a running sequence
    always_comb begin
        w_state  = r_state;
        w_tmr    = r_tmr + TW'(1);
        w_blinks = r_blinks;
        w_led    = 1'b0;
        case (r_state)
            IDLE: begin
                w_tmr = '0;
                w_led = r_multi;
                if (r_valid) begin
                    w_state  = ON;
                    w_blinks = {1'b0, r_index} + BW'(1);
                end
            end
            ON: begin
                w_led = 1'b1;
                if (r_tmr == BLINK_LAST) begin
                    w_state = OFF;
                    w_tmr   = '0;
                end
            end
            OFF: begin
                if (r_tmr == BLINK_LAST) begin
                    w_tmr    = '0;
                    w_blinks = r_blinks - BW'(1);
                    w_state  = (r_blinks > BW'(1)) ? ON : GAP;
                end
            end
            GAP: begin
                if (r_tmr == GAP_LAST) begin
                    w_state = IDLE;
                    w_tmr   = '0;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.pin_index = r_index;
    assign bus.pin_valid = r_valid;
    assign bus.pin_multi = r_multi;
    assign bus.led       = w_led;
endmodule

// File: tb/tb_pin_probe.sv
// Scoreboard bench for pin_probe: status changes and blink sequences are queued and checked by monitors.
module tb_pin_probe;
    localparam int W    = 48;
    localparam int STB  = 4;
    localparam int BLK  = 3;
    localparam int GAPC = 5;

    typedef struct {
        logic       valid;
        logic       multi;
        logic [5:0] idx;
        int         cyc;
    } st_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    st_t  st_q[$];
    int   blink_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pin_probe_if #(.WIDTH(W)) bus();

    pin_probe #(
        .WIDTH(W), .STABLE_CYCLES(STB), .BLINK_CYCLES(BLK), .GAP_CYCLES(GAPC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic logic [W-1:0] bit_of(input int i);
        logic [W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_st(input logic v, input logic m, input int idx, input int dly);
        st_t e;
        e.valid = v;
        e.multi = m;
        e.idx   = 6'(idx);
        e.cyc   = cyc + dly;
        st_q.push_back(e);
    endtask

    // status monitor: every change of {valid,multi,index} outside reset must match the next queued entry
    initial begin
        logic [7:0] cur, last;
        st_t e;
        last = '0;
        forever begin
            @(negedge clk);
            cur = {bus.pin_valid, bus.pin_multi, bus.pin_index};
            if (!resetn) begin
                last = cur;
            end else if (cur !== last) begin
                last = cur;
                n_tests++;
                if (st_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL status_unexpected: got v=%0d m=%0d idx=%0d at cycle %0d, expected no change",
                             cur[7], cur[6], cur[5:0], cyc);
                end else begin
                    e = st_q.pop_front();
                    if (cur !== {e.valid, e.multi, e.idx} || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL status: got v=%0d m=%0d idx=%0d @%0d, expected v=%0d m=%0d idx=%0d @%0d",
                                 cur[7], cur[6], cur[5:0], cyc, e.valid, e.multi, e.idx, e.cyc);
                    end
                end
            end
        end
    end

    // blink monitor: pulses must be BLK wide; a low run longer than BLK closes a sequence
    initial begin
        int hi, lo, pulses, e;
        hi = 0; lo = 0; pulses = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hi = 0; lo = 0; pulses = 0;
            end else if (bus.led === 1'b1) begin
                hi++;
                lo = 0;
            end else begin
                if (hi > 0 && hi <= BLK) begin
                    n_tests++;
                    if (hi != BLK) begin
                        n_fail++;
                        $display("FAIL blink_width: got %0d cycles high, expected %0d (cycle %0d)", hi, BLK, cyc);
                    end
                    pulses++;
                end
                hi = 0;
                lo++;
                if (lo == BLK + 1 && pulses > 0) begin
                    n_tests++;
                    if (blink_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL blink_unexpected: got sequence of %0d, expected none (cycle %0d)", pulses, cyc);
                    end else begin
                        e = blink_q.pop_front();
                        if (pulses != e) begin
                            n_fail++;
                            $display("FAIL blink_count: got %0d blinks, expected %0d (cycle %0d)", pulses, e, cyc);
                        end
                    end
                    pulses = 0;
                end
            end
        end
    end

    initial begin
        int bad_v, bad_i, bad_l;
        // 1: reset with bit 7 held high, then release and let two sequences run
        bus.PMOD = bit_of(7);
        step(3);
        chk("rst_index", bus.pin_index, 0);
        chk("rst_valid", bus.pin_valid, 0);
        chk("rst_multi", bus.pin_multi, 0);
        chk("rst_led",   bus.led,       0);
        resetn = 1'b1;
        exp_st(1, 0, 7, 6);
        blink_q.push_back(8);
        blink_q.push_back(8);
        step(60);
        bus.PMOD = '0;
        exp_st(0, 0, 7, 6);
        step(120);

        // 2a: lowest pin -> one blink per sequence
        bus.PMOD = bit_of(0);
        exp_st(1, 0, 0, 6);
        blink_q.push_back(1);
        blink_q.push_back(1);
        step(15);
        bus.PMOD = '0;
        exp_st(0, 0, 0, 6);
        step(40);

        // 2b: highest pin -> 48 blinks
        bus.PMOD = bit_of(47);
        exp_st(1, 0, 47, 6);
        blink_q.push_back(48);
        step(10);
        bus.PMOD = '0;
        exp_st(0, 0, 47, 6);
        step(320);

        // 3: a glitch one cycle short of qualifying changes nothing
        bus.PMOD = bit_of(12);
        bad_v = 0; bad_i = 0; bad_l = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (i == 2) bus.PMOD = '0;
            if (bus.pin_valid !== 1'b0) bad_v++;
            if (bus.pin_index !== 6'd47) bad_i++;
            if (bus.led !== 1'b0) bad_l++;
        end
        chk("glitch_valid_cycles", bad_v, 0);
        chk("glitch_index_cycles", bad_i, 0);
        chk("glitch_led_cycles",   bad_l, 0);

        // 4: two pins high -> fault, steady LED; then drop one and qualify the other
        bus.PMOD = bit_of(3) | bit_of(9);
        exp_st(0, 1, 47, 6);
        step(8);
        chk("multi_led_a",   bus.led,       1);
        chk("multi_valid",   bus.pin_valid, 0);
        step(2);
        chk("multi_led_b",   bus.led,       1);
        step(2);
        bus.PMOD = bit_of(3);
        exp_st(1, 0, 3, 6);
        blink_q.push_back(4);
        step(10);
        bus.PMOD = '0;
        exp_st(0, 0, 3, 6);
        step(50);

        // 5: index changes mid-sequence; running sequence keeps its count
        bus.PMOD = bit_of(5);
        exp_st(1, 0, 5, 6);
        blink_q.push_back(6);
        blink_q.push_back(3);
        step(15);
        bus.PMOD = bit_of(2);
        exp_st(1, 0, 2, 6);
        step(35);
        bus.PMOD = '0;
        exp_st(0, 0, 2, 6);
        step(40);

        // 6: reset while the LED is on aborts the sequence at once
        bus.PMOD = bit_of(1);
        exp_st(1, 0, 1, 6);
        step(8);
        chk("pre_rst_led_on", bus.led, 1);
        resetn   = 1'b0;
        bus.PMOD = '0;
        step(1);
        chk("midrst_led",   bus.led,       0);
        chk("midrst_valid", bus.pin_valid, 0);
        chk("midrst_index", bus.pin_index, 0);
        chk("midrst_multi", bus.pin_multi, 0);
        step(2);
        resetn = 1'b1;
        step(20);

        chk("status_queue_left", st_q.size(),    0);
        chk("blink_queue_left",  blink_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
